// File: rtl/defuse_scheduler.sv
// rtl/defuse_scheduler.sv - issues single-cycle defuse pulses from player clicks and buffered auto-reveal requests
module defuse_scheduler #(
  parameter int FIFO_DEPTH    = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] level,
  input  logic       game_over,
  input  logic       click_req,
  input  logic [4:0] click_x,
  input  logic [4:0] click_y,
  input  logic       fill_valid,
  output logic       fill_ready,
  input  logic [4:0] fill_x,
  input  logic [4:0] fill_y,
  output logic       defuse,
  output logic [4:0] defuse_ind_x,
  output logic [4:0] defuse_ind_y,
  output logic       busy,
  output logic       click_dropped,
  output logic       fill_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     level_q;
  logic           pend;
  logic [4:0]     pend_x;
  logic [4:0]     pend_y;
  logic [9:0]     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  logic [4:0]     size;
  logic           flush;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic           click_ok;

  function automatic logic coord_ok(input logic [4:0] x, input logic [4:0] y,
                                    input logic [4:0] n);
    return (x != 5'd0) && (x <= n) && (y != 5'd0) && (y <= n);
  endfunction

  always_comb begin
    size = 5'd0;
    case (level)
      2'd1:    size = 5'd8;
      2'd2:    size = 5'd10;
      2'd3:    size = 5'd16;
      default: size = 5'd0;
    endcase
  end

  // A level change behaves like game_over for one cycle: everything queued belongs to the old board.
  assign flush      = game_over || (level != level_q);
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == IDLE) && !pend && !empty && !flush;
  assign fill_ready = !game_over && (!full || pop);
  assign push       = fill_valid && fill_ready && coord_ok(fill_x, fill_y, size) && !flush;
  // A pending click being served this cycle frees the slot for a new one.
  assign click_ok   = click_req && coord_ok(click_x, click_y, size) && !flush &&
                      (!pend || (state == IDLE));
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {fill_x, fill_y};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      level_q       <= 2'd0;
      pend          <= 1'b0;
      pend_x        <= 5'd0;
      pend_y        <= 5'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      defuse        <= 1'b0;
      defuse_ind_x  <= 5'd0;
      defuse_ind_y  <= 5'd0;
      click_dropped <= 1'b0;
      fill_overflow <= 1'b0;
    end else begin
      level_q       <= level;
      click_dropped <= click_req && !click_ok;
      defuse        <= 1'b0;

      if (level != level_q)
        fill_overflow <= 1'b0;
      else if (fill_valid && full && !pop)
        fill_overflow <= 1'b1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (flush)
        pend <= 1'b0;
      else if (click_ok) begin
        pend   <= 1'b1;
        pend_x <= click_x;
        pend_y <= click_y;
      end else if ((state == IDLE) && pend)
        pend <= 1'b0;

      case (state)
        IDLE: begin
          if (!flush && pend) begin
            defuse_ind_x <= pend_x;
            defuse_ind_y <= pend_y;
            defuse       <= 1'b1;
            state        <= ISSUE;
          end else if (pop) begin
            {defuse_ind_x, defuse_ind_y} <= mem[rd_ptr[AW-1:0]];
            defuse       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_defuse_scheduler.sv
// tb/tb_defuse_scheduler.sv - directed vector and sequence bench for defuse_scheduler
module tb_defuse_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] level;
  logic       game_over;
  logic       click_req;
  logic [4:0] click_x;
  logic [4:0] click_y;
  logic       fill_valid;
  logic       fill_ready;
  logic [4:0] fill_x;
  logic [4:0] fill_y;
  logic       defuse;
  logic [4:0] defuse_ind_x;
  logic [4:0] defuse_ind_y;
  logic       busy;
  logic       click_dropped;
  logic       fill_overflow;

  defuse_scheduler #(.FIFO_DEPTH(16), .SETTLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .level(level), .game_over(game_over),
    .click_req(click_req), .click_x(click_x), .click_y(click_y),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_x(fill_x), .fill_y(fill_y),
    .defuse(defuse), .defuse_ind_x(defuse_ind_x), .defuse_ind_y(defuse_ind_y),
    .busy(busy), .click_dropped(click_dropped), .fill_overflow(fill_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lvl;
    logic [4:0] x;
    logic [4:0] y;
    logic       acc;
  } vec_t;

  typedef struct {
    int         c;
    logic [4:0] x;
    logic [4:0] y;
  } pulse_t;

  vec_t   vecs [8];
  pulse_t pulses [$];
  int     cyc;
  int     total = 0;
  int     passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (defuse) pulses.push_back('{cyc, defuse_ind_x, defuse_ind_y});
  endtask

  task automatic chk_pulse(input int idx, input int c, input int x, input int y);
    if (pulses.size() > idx)
      chk($sformatf("pulse%0d cyc*1024+x*32+y", idx),
          pulses[idx].c * 1024 + int'(pulses[idx].x) * 32 + int'(pulses[idx].y),
          c * 1024 + x * 32 + y);
    else
      chk($sformatf("pulse%0d count", idx), pulses.size(), idx + 1);
  endtask

  initial begin
    vecs[0] = '{2'd1, 5'd3,  5'd4,  1'b1};
    vecs[1] = '{2'd1, 5'd9,  5'd1,  1'b0};
    vecs[2] = '{2'd3, 5'd16, 5'd16, 1'b1};
    vecs[3] = '{2'd2, 5'd10, 5'd10, 1'b1};
    vecs[4] = '{2'd2, 5'd11, 5'd3,  1'b0};
    vecs[5] = '{2'd0, 5'd1,  5'd1,  1'b0};
    vecs[6] = '{2'd1, 5'd0,  5'd5,  1'b0};
    vecs[7] = '{2'd1, 5'd8,  5'd8,  1'b1};

    rst = 1'b0; level = 2'd1; game_over = 1'b0; click_req = 1'b0;
    click_x = 5'd0; click_y = 5'd0; fill_valid = 1'b0; fill_x = 5'd0; fill_y = 5'd0;
    cyc = 0;
    tick(); tick();
    chk("reset defuse", defuse, 0);
    chk("reset busy", busy, 0);
    chk("reset fill_ready", fill_ready, 1);
    chk("reset click_dropped", click_dropped, 0);
    chk("reset fill_overflow", fill_overflow, 0);
    chk("reset ind", {defuse_ind_x, defuse_ind_y}, 0);
    rst = 1'b1;
    repeat (3) tick();

    // Click vectors: result appears one cycle (drop) or two cycles (pulse) after the request.
    for (int i = 0; i < 8; i++) begin
      level = vecs[i].lvl;
      tick(); tick();
      pulses.delete(); cyc = 0;
      click_req = 1'b1; click_x = vecs[i].x; click_y = vecs[i].y;
      tick();
      click_req = 1'b0;
      chk($sformatf("v%0d click_dropped", i), click_dropped, !vecs[i].acc);
      chk($sformatf("v%0d defuse@1", i), defuse, 0);
      tick();
      chk($sformatf("v%0d defuse@2", i), defuse, vecs[i].acc);
      if (vecs[i].acc)
        chk($sformatf("v%0d ind", i), {defuse_ind_x, defuse_ind_y}, {vecs[i].x, vecs[i].y});
      repeat (8) tick();
      chk($sformatf("v%0d busy@10", i), busy, vecs[i].acc);
      tick();
      chk($sformatf("v%0d busy@11", i), busy, 0);
      chk($sformatf("v%0d pulse count", i), pulses.size(), vecs[i].acc ? 1 : 0);
    end

    // Fill drain: three pushes, pulses SETTLE_CYCLES+2 apart in push order.
    level = 2'd1; tick(); tick();
    pulses.delete(); cyc = 0;
    fill_valid = 1'b1; fill_x = 5'd1; fill_y = 5'd1;
    tick(); fill_x = 5'd1; fill_y = 5'd2;
    tick(); fill_x = 5'd2; fill_y = 5'd1;
    tick(); fill_valid = 1'b0;
    repeat (32) tick();
    chk("drain count", pulses.size(), 3);
    chk_pulse(0, 2, 1, 1);
    chk_pulse(1, 12, 1, 2);
    chk_pulse(2, 22, 2, 1);
    chk("drain busy", busy, 0);

    // Priority: a click arriving during SETTLE beats the queued fill entry.
    pulses.delete(); cyc = 0;
    click_req = 1'b1; click_x = 5'd1; click_y = 5'd1;
    tick(); click_req = 1'b0;
    fill_valid = 1'b1; fill_x = 5'd2; fill_y = 5'd2;
    tick(); fill_valid = 1'b0;
    tick(); click_req = 1'b1; click_x = 5'd5; click_y = 5'd5;
    tick(); click_x = 5'd6; click_y = 5'd6;
    chk("prio first click kept", click_dropped, 0);
    tick(); click_req = 1'b0;
    chk("prio second click dropped", click_dropped, 1);
    repeat (20) tick();
    chk("prio count", pulses.size(), 3);
    chk_pulse(0, 2, 1, 1);
    chk_pulse(1, 12, 5, 5);
    chk_pulse(2, 22, 2, 2);
    repeat (10) tick();

    // Full FIFO, overflow, push+pop at full, then game_over flush and level-change clear.
    pulses.delete(); cyc = 0;
    for (int k = 0; k < 45; k++) begin
      fill_valid = (k < 25);
      fill_x = 5'((k % 8) + 1); fill_y = 5'd1;
      game_over = (k >= 25) && (k < 40);
      if (k == 41) level = 2'd2;
      if (k == 17) chk("full ready@17", fill_ready, 1);
      if (k == 18) chk("full ready@18", fill_ready, 0);
      if (k == 18) chk("overflow@18", fill_overflow, 0);
      if (k == 19) chk("overflow@19", fill_overflow, 1);
      if (k == 21) chk("full pushpop ready@21", fill_ready, 1);
      if (k == 22) chk("full still full@22", fill_ready, 0);
      if (k == 25) chk("game_over ready", fill_ready, 0);
      if (k == 26) chk("game_over settle busy", busy, 1);
      if (k == 31) chk("game_over idle busy", busy, 0);
      if (k == 40) chk("overflow sticky over game_over", fill_overflow, 1);
      if (k == 42) chk("level change clears overflow", fill_overflow, 0);
      if (k == 44) chk("flushed busy", busy, 0);
      tick();
    end
    chk("full pulse count", pulses.size(), 3);
    chk_pulse(0, 2, 1, 1);
    chk_pulse(1, 12, 2, 1);
    chk_pulse(2, 22, 3, 1);

    // Asynchronous reset during the pulse with an entry queued.
    level = 2'd1; tick(); tick();
    pulses.delete(); cyc = 0;
    click_req = 1'b1; click_x = 5'd3; click_y = 5'd4;
    tick(); click_req = 1'b0;
    fill_valid = 1'b1; fill_x = 5'd2; fill_y = 5'd2;
    tick(); fill_valid = 1'b0;
    chk("pre-reset defuse", defuse, 1);
    #1 rst = 1'b0;
    #1;
    chk("async defuse", defuse, 0);
    chk("async ind", {defuse_ind_x, defuse_ind_y}, 0);
    chk("async busy", busy, 0);
    chk("async fill_ready", fill_ready, 1);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
